// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer slice:
//   - op codes presented by decode (OP_MULT .. OP_MTLO; 6 and 7 reserved)
//   - controller state encoding
//   - unit_sel encodings (multiply vs divide)
//   - small decode helpers used by the controller
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam logic SEL_MUL = 1'b0;
  localparam logic SEL_DIV = 1'b1;

  // Op codes 0-3 launch the iterative unit; bit 1 selects divide and
  // bit 0 marks the unsigned flavour.
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op[2] == 1'b0) && (op[1] == 1'b1);
  endfunction

endpackage

// File: rtl/muldiv_wdog.sv
// muldiv_wdog
// Watchdog counter for an in-flight multiply/divide.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset
//   clear  - restart the count (held while the op is being issued)
//   enable - count this cycle (controller is waiting for the unit)
//   expire - high on the enabled cycle whose count reaches MAX_CYC-1
module muldiv_wdog
  import muldiv_pkg::*;
#(
  parameter int MAX_CYC = 64,
  parameter int CNT_W   = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count the cycles spent waiting; the count restarts on every issue.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // First wait cycle sees a count of 0, so MAX_CYC-1 marks the last
  // permitted wait cycle.
  assign expire = enable && (cnt_q == CNT_W'(MAX_CYC - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
// Sequencer for the CPU multiply/divide path and owner of HI/LO.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   op_valid/op/op_a/op_b - op from decode; op_ready accepts it (IDLE only)
//   flush                 - cancels any in-flight op, drops an IDLE op
//   rd_hilo / stall       - MFHI/MFLO in decode is frozen while busy
//   unit_start/sel/signed - launch pulse and mode for the iterative unit
//   unit_a / unit_b       - operands held for the unit
//   unit_abort            - one-cycle cancel pulse (flush or watchdog)
//   unit_done/hi/lo       - unit result handshake
//   hi / lo               - architectural HI/LO
//   busy / timeout_err    - not IDLE / sticky watchdog flag
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MAX_CYC = 64,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              op_ready,
  input  logic              flush,
  input  logic              rd_hilo,
  output logic              stall,
  output logic              unit_start,
  output logic              unit_sel,
  output logic              unit_signed,
  output logic [DATA_W-1:0] unit_a,
  output logic [DATA_W-1:0] unit_b,
  output logic              unit_abort,
  input  logic              unit_done,
  input  logic [DATA_W-1:0] unit_hi,
  input  logic [DATA_W-1:0] unit_lo,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              timeout_err
);

  state_e            state_q;
  logic [DATA_W-1:0] hi_q, lo_q, a_q, b_q;
  logic              sel_q, signed_q, abort_q, timeout_q;
  logic              wdog_expire;

  muldiv_wdog #(
    .MAX_CYC (MAX_CYC),
    .CNT_W   (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == ST_ISSUE),
    .enable (state_q == ST_WAIT),
    .expire (wdog_expire)
  );

  // Single sequencer: accepts ops in IDLE, launches in ISSUE, waits for
  // the unit in WAIT. Flush has priority over done, done over the
  // watchdog. Divides by zero are accepted but never launched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= SEL_MUL;
      signed_q  <= 1'b0;
      abort_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (op_valid && !flush) begin
            if (is_arith(op)) begin
              if (!is_div(op) || (op_b != '0)) begin
                a_q      <= op_a;
                b_q      <= op_b;
                sel_q    <= is_div(op) ? SEL_DIV : SEL_MUL;
                signed_q <= ~op[0];
                state_q  <= ST_ISSUE;
              end
            end else if (op == OP_MTHI) begin
              hi_q <= op_a;
            end else if (op == OP_MTLO) begin
              lo_q <= op_a;
            end
          end
        end
        ST_ISSUE: begin
          if (flush) begin
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            abort_q <= 1'b1;
            state_q <= ST_IDLE;
          end else if (unit_done) begin
            hi_q    <= unit_hi;
            lo_q    <= unit_lo;
            state_q <= ST_IDLE;
          end else if (wdog_expire) begin
            timeout_q <= 1'b1;
            abort_q   <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready    = (state_q == ST_IDLE);
  assign busy        = ~op_ready;
  assign stall       = rd_hilo & busy;
  // A flush in ISSUE must keep the launch from reaching the unit.
  assign unit_start  = (state_q == ST_ISSUE) & ~flush;
  assign unit_sel    = sel_q;
  assign unit_signed = signed_q;
  assign unit_a      = a_q;
  assign unit_b      = b_q;
  assign unit_abort  = abort_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign timeout_err = timeout_q;

endmodule
